branch_target_buffer: RTL
=========================

// Module: branch_target_buffer
// PURPOSE
//  Fetch-stage companion to the ID-stage direction predictor. Direct-mapped table of
//  taken-branch targets indexed by fetch PC; on hit the fetch unit redirects to target_out
//  when predict_taken is asserted. Written from WB when a BR/JSR resolves taken.
//  Keeps saturating hit/miss statistics for performance measurement.
// PARAMETERS
//  index_bits   4   log2(entries); entry index = PC[index_bits:0+1] (PC bit0 always 0)
//  tag_bits     15-index_bits (derived, localparam)  tag = PC[15:index_bits+1]
// PORTS
//  clk          in   1   clock, all state updates on rising edge
//  reset        in   1   synchronous, active-high
//  PC_if        in   16  fetch-stage PC (lc3b_word)
//  lookup_en    in   1   fetch stage valid and not stalled this cycle
//  hit          out  1   valid entry with matching tag for PC_if (combinational)
//  target_out   out  16  stored target for PC_if; 16'h0000 when hit=0
//  PC_wb        in   16  PC of the instruction in WB
//  target_wb    in   16  resolved target of the instruction in WB
//  opcode_wb    in   4   opcode in WB (lc3b_opcode)
//  taken_wb     in   1   instruction in WB redirected the PC (pcmux_sel != 0)
//  enable       in   1   WB stage valid/commit this cycle
//  hit_count    out  16  lookups that hit, saturating
//  miss_count   out  16  lookups that missed, saturating
// BEHAVIOUR
//  - Storage: 2**index_bits entries of {valid, tag, target}. Reset clears every valid bit
//    in one cycle; tag/target contents are don't-care after reset.
//  - Reset values: hit=0, target_out=0 (all entries invalid), hit_count=0, miss_count=0.
//  - Lookup: purely combinational from PC_if, zero latency; independent of lookup_en
//    (lookup_en only gates statistics).
//  - Update: wr = enable & taken_wb & (opcode_wb==op_br | opcode_wb==op_jsr).
//    On wr, entry[idx(PC_wb)] <= {1, tag(PC_wb), target_wb} at the next edge;
//    overwrites any existing entry (conflict replacement, no LRU).
//  - Not-taken branches never write or invalidate; direction is the predictor's job.
//  - Same-cycle update and lookup to the same index: lookup returns OLD contents;
//    new entry visible from the following cycle. No bypass.
//  - Statistics: if lookup_en, hit_count += hit else miss_count += 1; each saturates
//    at 16'hFFFF and holds. Exactly one counter moves per enabled lookup.
//  - reset asserted concurrently with wr or lookup_en: reset wins; no write, counters 0.
//  - reset mid-run discards all entries; first post-reset lookup of any PC misses.
//  - X on inputs while enable/lookup_en low must not corrupt state.
// TESTING
//  1 reset, lookup PC_if=16'h3000 -> hit=0, target_out=0, miss_count=1 after edge.
//  2 WB: enable=1, op_br, taken=1, PC_wb=16'h3004, target_wb=16'h3020; next cycle
//    PC_if=16'h3004 -> hit=1, target_out=16'h3020, hit_count increments.
//  3 alias (index_bits=4): fill 16'h3004 then lookup 16'h3024 (same idx, diff tag) ->
//    hit=0; write 16'h3024->16'h3100 then 16'h3004 misses, 16'h3024 hits 16'h3100.
//  4 same-cycle write 16'h3008->16'h3040 and lookup 16'h3008 -> hit=0 that cycle,
//    hit=1 target 16'h3040 next cycle.
//  5 taken_wb=0 op_br, or taken op_add/enable=0 -> table unchanged, prior hits persist.
//  6 force miss_count to 16'hFFFE, 3 missing lookups -> 16'hFFFF, holds; reset
//    during an update cycle -> all lookups miss, both counters 0.

Source files
------------

// File: rtl/branch_target_buffer.sv
// Direct-mapped branch target buffer: fetch-PC lookup, WB-stage fill on taken BR/JSR, hit/miss stats.
// Latency: lookup is combinational (0 cycles); a write becomes visible the cycle after it is presented.
// Backpressure: none; lookup_en and enable only qualify statistics and writes.
module branch_target_buffer #(
   parameter int index_bits = 4
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [15:0] PC_if,
   input  logic        lookup_en,
   output logic        hit,
   output logic [15:0] target_out,
   input  logic [15:0] PC_wb,
   input  logic [15:0] target_wb,
   input  logic [3:0]  opcode_wb,
   input  logic        taken_wb,
   input  logic        enable,
   output logic [15:0] hit_count,
   output logic [15:0] miss_count
);

   localparam int entries  = 1 << index_bits;
   localparam int tag_bits = 15 - index_bits;

   localparam logic [3:0] op_br  = 4'b0000;
   localparam logic [3:0] op_jsr = 4'b0100;

   typedef struct packed {
      logic [tag_bits-1:0] tag;
      logic [15:0]         target;
   } entry_t;

   // Valid bits carry the reset; tag/target storage is left unreset since an
   // invalid entry's payload is never observed.
   logic [entries-1:0] valid_q;
   entry_t             entry_q [entries];

   logic [index_bits-1:0] idx_if;
   logic [index_bits-1:0] idx_wb;
   logic [tag_bits-1:0]   tag_if;
   logic [tag_bits-1:0]   tag_wb;
   entry_t                rd_entry;
   entry_t                wr_entry;
   logic                  is_ctrl_op;
   logic                  wr;

   // PC bit 0 is always zero for LC-3b instructions, so it never selects an entry.
   logic unused_pc_lsb;
   assign unused_pc_lsb = PC_if[0] ^ PC_wb[0];

   assign idx_if = PC_if[index_bits:1];
   assign tag_if = PC_if[15:index_bits+1];
   assign idx_wb = PC_wb[index_bits:1];
   assign tag_wb = PC_wb[15:index_bits+1];

   assign rd_entry   = entry_q[idx_if];
   assign hit        = valid_q[idx_if] && (rd_entry.tag == tag_if);
   assign target_out = hit ? rd_entry.target : 16'h0000;

   assign is_ctrl_op = (opcode_wb == op_br) || (opcode_wb == op_jsr);
   assign wr         = enable && taken_wb && is_ctrl_op;

   assign wr_entry.tag    = tag_wb;
   assign wr_entry.target = target_wb;

   always_ff @(posedge clk) begin
      if (reset) begin
         valid_q <= '0;
      end else if (wr) begin
         valid_q[idx_wb] <= 1'b1;
      end
   end

   // No read bypass: a same-cycle lookup of the written index sees the old entry.
   always_ff @(posedge clk) begin
      if (wr && !reset) begin
         entry_q[idx_wb] <= wr_entry;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         hit_count  <= 16'h0000;
         miss_count <= 16'h0000;
      end else if (lookup_en) begin
         if (hit) begin
            if (hit_count != 16'hFFFF) begin
               hit_count <= hit_count + 16'h0001;
            end
         end else if (miss_count != 16'hFFFF) begin
            miss_count <= miss_count + 16'h0001;
         end
      end
   end

endmodule
